// File: rtl/bus_sequencer_n.sv
// Sequences single-word bus phases (SRC/DST), hands multi-word ops to DMA, services I/O interrupts when idle; ROUND_ROBIN_IRQ_EN rotates IRQ priority.
// Latency 1-2 cycles per transfer; backpressure: instr_ready low outside IDLE, or while busybus blocks a bus-using class.
module bus_sequencer_n #(
  parameter int ADDR_W  = 8,
  parameter int CNT_W   = 6,
  parameter int INSTR_W = 26,
  parameter int NUM_IO  = 2,
  parameter int IO_BASE = 192,
  parameter int IO_SPAN = 32
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic [INSTR_W-1:0] instr,
  input  logic [ADDR_W-1:0]  source,
  input  logic [ADDR_W-1:0]  destination,
  input  logic [ADDR_W-1:0]  irq_base,
  input  logic               busybus,
  input  logic [NUM_IO-1:0]  io_irq,
  output logic [ADDR_W-1:0]  bus_addr,
  output logic               addr_valid,
  output logic [NUM_IO-1:0]  io_write,
  output logic               mem_write,
  output logic [NUM_IO-1:0]  io_ack,
  output logic               grant,
  output logic               dma_valid,
  output logic [INSTR_W-1:0] dma_instr,
  input  logic               dma_accept,
  output logic               addr_err
);

  typedef enum logic [2:0] {S_IDLE, S_SRC, S_DST, S_DMA, S_ALU, S_IRQ} state_t;
  typedef enum logic [3:0] {
    C_NONE, C_R2IO, C_IO2R, C_R2M, C_M2R, C_M2IO, C_IO2M, C_M2M, C_DMA, C_ALU
  } cls_t;

  function automatic logic [31:0] io_idx(input logic [ADDR_W-1:0] a);
    io_idx = (32'(a) - 32'(IO_BASE)) / 32'(IO_SPAN);
  endfunction

  function automatic logic io_hit(input logic [ADDR_W-1:0] a);
    io_hit = (32'(a) >= 32'(IO_BASE)) && (io_idx(a) < 32'(NUM_IO));
  endfunction

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   src_q, src_d, dst_q, dst_d, irqa_q, irqa_d;
  logic [NUM_IO-1:0]   iow_q, iow_d, ack_q, ack_d;
  logic                mw_src_q, mw_src_d, mw_dst_q, mw_dst_d, two_q, two_d;
  logic                addr_err_q, addr_err_d;
  logic [INSTR_W-1:0]  dinst_q, dinst_d;

  cls_t                cls;
  logic [NUM_IO-1:0]   dst_oh, sel;
  logic                bad, accept, found;

`ifdef ROUND_ROBIN_IRQ_EN
  localparam int PW = (NUM_IO > 1) ? $clog2(NUM_IO) : 1;
  logic [PW-1:0] ptr_q, ptr_d;
  int            sel_idx;
`endif

  always_comb begin
    cls = C_NONE;
    case (instr[25:22])
      4'b0011: cls = C_R2IO;
      4'b0111: cls = C_IO2R;
      4'b0000: cls = C_R2M;
      4'b0100: cls = C_M2R;
      4'b0101: cls = (instr[CNT_W-1:0] == '0) ? C_M2IO : C_DMA;
      4'b0001: cls = (instr[CNT_W-1:0] == '0) ? C_IO2M : C_DMA;
      4'b0110: cls = (instr[CNT_W-1:0] == '0) ? C_M2M  : C_DMA;
      default: cls = instr[25] ? C_ALU : C_NONE;
    endcase
  end

  always_comb begin
    dst_oh = '0;
    for (int k = 0; k < NUM_IO; k++)
      if (io_idx(destination) == 32'(k)) dst_oh[k] = io_hit(destination);
    bad = (((cls == C_R2IO) || (cls == C_M2IO)) && !io_hit(destination)) ||
          (((cls == C_IO2R) || (cls == C_IO2M)) && !io_hit(source));
    instr_ready = !reset && (state_q == S_IDLE) &&
                  (!busybus || (cls == C_ALU) || (cls == C_DMA));
    accept = instr_valid && instr_ready && (cls != C_NONE);
  end

  // Interrupt pick: fixed priority from 0, or rotating from ptr_q.
  always_comb begin
    sel   = '0;
    found = 1'b0;
`ifdef ROUND_ROBIN_IRQ_EN
    sel_idx = 0;
    for (int i = 0; i < NUM_IO; i++) begin
      int k;
      k = (int'(ptr_q) + i) % NUM_IO;
      if (!found && io_irq[k]) begin
        found   = 1'b1;
        sel[k]  = 1'b1;
        sel_idx = k;
      end
    end
`else
    for (int i = 0; i < NUM_IO; i++) begin
      if (!found && io_irq[i]) begin
        found  = 1'b1;
        sel[i] = 1'b1;
      end
    end
`endif
  end

  always_comb begin
    state_d    = state_q;
    src_d      = src_q;
    dst_d      = dst_q;
    irqa_d     = irqa_q;
    iow_d      = iow_q;
    ack_d      = ack_q;
    mw_src_d   = mw_src_q;
    mw_dst_d   = mw_dst_q;
    two_d      = two_q;
    dinst_d    = dinst_q;
    addr_err_d = 1'b0;
`ifdef ROUND_ROBIN_IRQ_EN
    ptr_d      = ptr_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          case (cls)
            C_ALU: state_d = S_ALU;
            C_DMA: begin
              state_d = S_DMA;
              dinst_d = instr;
            end
            default: begin
              if (bad) begin
                addr_err_d = 1'b1;
              end else begin
                src_d    = source;
                dst_d    = destination;
                iow_d    = ((cls == C_R2IO) || (cls == C_M2IO)) ? dst_oh : '0;
                mw_src_d = (cls == C_IO2M);
                mw_dst_d = (cls == C_R2M) || (cls == C_IO2M) || (cls == C_M2M);
                two_d    = (cls == C_M2IO) || (cls == C_IO2M) || (cls == C_M2M);
                state_d  = ((cls == C_R2IO) || (cls == C_R2M)) ? S_DST : S_SRC;
              end
            end
          endcase
        end else if (found && !busybus) begin
          state_d = S_IRQ;
          ack_d   = sel;
          irqa_d  = irq_base;
`ifdef ROUND_ROBIN_IRQ_EN
          ptr_d   = PW'((sel_idx + 1) % NUM_IO);
`endif
        end
      end
      S_SRC:   state_d = two_q ? S_DST : S_IDLE;
      S_DMA:   if (dma_accept) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus_addr   = '0;
    addr_valid = 1'b0;
    io_write   = '0;
    mem_write  = 1'b0;
    io_ack     = '0;
    grant      = 1'b0;
    dma_valid  = 1'b0;
    dma_instr  = '0;
    addr_err   = addr_err_q;
    case (state_q)
      S_SRC: begin
        bus_addr   = src_q;
        addr_valid = 1'b1;
        io_write   = iow_q;
        mem_write  = mw_src_q;
      end
      S_DST: begin
        bus_addr   = dst_q;
        addr_valid = 1'b1;
        io_write   = iow_q;
        mem_write  = mw_dst_q;
      end
      S_IRQ: begin
        bus_addr   = irqa_q;
        addr_valid = 1'b1;
        mem_write  = 1'b1;
        io_ack     = ack_q;
      end
      S_DMA: begin
        grant     = 1'b1;
        dma_valid = 1'b1;
        dma_instr = dinst_q;
      end
      S_ALU:   grant = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      src_q      <= '0;
      dst_q      <= '0;
      irqa_q     <= '0;
      iow_q      <= '0;
      ack_q      <= '0;
      mw_src_q   <= 1'b0;
      mw_dst_q   <= 1'b0;
      two_q      <= 1'b0;
      dinst_q    <= '0;
      addr_err_q <= 1'b0;
`ifdef ROUND_ROBIN_IRQ_EN
      ptr_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      src_q      <= src_d;
      dst_q      <= dst_d;
      irqa_q     <= irqa_d;
      iow_q      <= iow_d;
      ack_q      <= ack_d;
      mw_src_q   <= mw_src_d;
      mw_dst_q   <= mw_dst_d;
      two_q      <= two_d;
      dinst_q    <= dinst_d;
      addr_err_q <= addr_err_d;
`ifdef ROUND_ROBIN_IRQ_EN
      ptr_q      <= ptr_d;
`endif
    end
  end

endmodule
